fp_sub_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision subtractor. Computes result = A - B.
- Sits beside the combinational float adder in the arithmetic datapath and follows the same numeric rules:
  - hidden bit is 0 when the exponent is 0
  - alignment and normalisation truncate; there is no rounding
  - exception is raised on an all-ones exponent, and the result is then forced to 0
- Uses a valid/ready handshake on both sides. Alignment and normalisation run one bit per cycle, so latency depends on the data.

---
 rtl/fp_sub_seq_if.sv | 31 +++
 rtl/fp_sub_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sub_seq_if.sv
// ---------------------------------------------------------------------------
// fp_sub_seq_if
// Operand/result handshake bundle for the sequential float subtractor.
//   in_valid / in_ready : operand handshake (a, b accepted on in_valid & in_ready)
//   a, b                : IEEE-754 single operands, result = a - b
//   out_valid/out_ready : result handshake
//   result, exception   : held stable while out_valid is high
//   busy                : block is working on (or holding) an operation
// master = producer/consumer side, slave = the subtractor.
// ---------------------------------------------------------------------------
interface fp_sub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        exception;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, exception, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, exception, busy
    );
endinterface

// File: rtl/fp_sub_seq.sv
// ---------------------------------------------------------------------------
// fp_sub_seq
// Multi-cycle IEEE-754 single-precision subtractor, result = a - b.
// Numeric behaviour matches the combinational float adder: hidden bit is 0
// for exponent 0, alignment and normalisation truncate, an all-ones input
// exponent (or a carry into exponent 0xFF) raises exception with result 0.
// Alignment and normalisation move one bit per cycle.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fp_sub_seq_if.slave: in_valid/in_ready/a/b operand handshake,
//          out_valid/out_ready/result/exception result handshake, busy
// Parameter:
//   MAX_ALIGN - saturation of the alignment shift count
// ---------------------------------------------------------------------------
module fp_sub_seq #(
    parameter int MAX_ALIGN = 25
) (
    input  logic         clk,
    input  logic         rst,
    fp_sub_seq_if.slave  bus
);

    localparam int CW = $clog2(MAX_ALIGN + 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        COMPUTE,
        NORM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Working registers
    logic          sign_r;      // sign of the larger-magnitude operand
    logic          sub_r;       // effective subtraction
    logic          exc_in_r;    // an operand had exponent 0xFF
    logic [7:0]    exp_r;       // working exponent
    logic [23:0]   mant_max_r;
    logic [23:0]   mant_min_r;
    logic [CW-1:0] count_r;     // remaining alignment shifts
    logic [24:0]   mant_r;      // sum/difference being normalised
    logic [31:0]   result_r;
    logic          exc_r;

    // Operand ordering, evaluated on the raw inputs at acceptance
    logic [31:0]   b_neg;
    logic          a_is_max;
    logic [31:0]   op_max;
    logic [31:0]   op_min;
    logic [7:0]    exp_diff;
    logic [CW-1:0] shift_sat;
    logic          in_exc;

    always_comb begin
        b_neg     = {~bus.b[31], bus.b[30:0]};
        a_is_max  = (bus.a[30:0] >= b_neg[30:0]);
        op_max    = a_is_max ? bus.a : b_neg;
        op_min    = a_is_max ? b_neg : bus.a;
        // Magnitude ordering guarantees exp(max) >= exp(min): no wrap.
        exp_diff  = op_max[30:23] - op_min[30:23];
        shift_sat = (exp_diff > 8'(MAX_ALIGN)) ? CW'(MAX_ALIGN) : CW'(exp_diff);
        in_exc    = (&bus.a[30:23]) | (&bus.b[30:23]);
    end

    // Normalisation decisions for the current NORM cycle
    logic norm_carry;
    logic norm_left;

    assign norm_carry = mant_r[24];
    assign norm_left  = !mant_r[23] && (mant_r != '0) && (exp_r > 8'd1);

    // Packing of the normalised value
    logic [7:0]  pack_exp;
    logic [31:0] pack_word;
    logic        pack_exc;

    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pack_exp  = 8'd0;
        pack_word = 32'd0;
        pack_exc  = 1'b0;
        if (mant_r[23]) begin
            // Two denormals summing into bit 23 become the smallest normal.
            pack_exp = (exp_r == 8'd0) ? 8'd1 : exp_r;
        end
        if (exp_r == 8'hFF) begin
            pack_exc = 1'b1;
        end else if (mant_r != '0) begin
            pack_word = {sign_r, pack_exp, mant_r[22:0]};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    logic in_ready_c;
    logic out_valid_c;
    logic busy_c;

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) state_next = ALIGN;
            end
            ALIGN: begin
                if (exc_in_r)            state_next = DONE;
                else if (count_r == '0)  state_next = COMPUTE;
            end
            COMPUTE: state_next = NORM;
            NORM: begin
                if (!norm_carry && !norm_left) state_next = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.result    = result_r;
    assign bus.exception = exc_r;

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r     <= 1'b0;
            sub_r      <= 1'b0;
            exc_in_r   <= 1'b0;
            exp_r      <= 8'd0;
            mant_max_r <= 24'd0;
            mant_min_r <= 24'd0;
            count_r    <= '0;
            mant_r     <= 25'd0;
            result_r   <= 32'd0;
            exc_r      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r     <= op_max[31];
                        sub_r      <= op_max[31] ^ op_min[31];
                        exc_in_r   <= in_exc;
                        exp_r      <= op_max[30:23];
                        mant_max_r <= {|op_max[30:23], op_max[22:0]};
                        mant_min_r <= {|op_min[30:23], op_min[22:0]};
                        count_r    <= shift_sat;
                    end
                end
                ALIGN: begin
                    if (exc_in_r) begin
                        result_r <= 32'd0;
                        exc_r    <= 1'b1;
                    end else if (count_r != '0) begin
                        mant_min_r <= mant_min_r >> 1;
                        count_r    <= count_r - 1'b1;
                    end
                end
                COMPUTE: begin
                    // max >= min in magnitude, so the difference never wraps.
                    mant_r <= sub_r ? ({1'b0, mant_max_r} - {1'b0, mant_min_r})
                                    : ({1'b0, mant_max_r} + {1'b0, mant_min_r});
                end
                NORM: begin
                    if (norm_carry) begin
                        mant_r <= mant_r >> 1;
                        exp_r  <= exp_r + 8'd1;
                    end else if (norm_left) begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - 8'd1;
                    end else begin
                        result_r <= pack_word;
                        exc_r    <= pack_exc;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_sub_seq
// Self-checking bench for fp_sub_seq. A table of operand pairs with
// hand-derived results, exception flags and latencies is driven through the
// input handshake; expected values go into a scoreboard queue and are
// compared when the result handshake completes. Hand-written sequences cover
// reset state, backpressure and reset during alignment.
// ---------------------------------------------------------------------------
module tb_fp_sub_seq;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_sub_seq_if bus ();

    fp_sub_seq #(.MAX_ALIGN(25)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;   // edge after which out_valid rises, counted from acceptance
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   seen      = 1'b0;
    int   first_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one operand pair and push its expectation once accepted.
    task automatic drive(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check({name, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.name    = name;
        e.res     = res;
        e.exc     = exc;
        e.lat     = lat;
        e.acc_cyc = cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Result monitor: records when out_valid rises, compares on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (bus.out_valid) begin
                if (!seen) begin
                    seen      = 1'b1;
                    first_cyc = cyc;
                end
                if (bus.out_ready) begin
                    seen = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_result"},    bus.result,                e.res);
                        check({e.name, "_exception"}, 32'(bus.exception),        32'(e.exc));
                        check({e.name, "_latency"},   32'(first_cyc - e.acc_cyc), 32'(e.lat));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"basic_sub",   32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4};
        vecs[1]  = '{"left_norm",   32'h3FC00000, 32'h3FA00000, 32'h3E800000, 1'b0, 5};
        vecs[2]  = '{"equal_zero",  32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 3};
        vecs[3]  = '{"carry_add",   32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 4};
        vecs[4]  = '{"align_sat",   32'h4E800000, 32'h3F800000, 32'h4E800000, 1'b0, 28};
        vecs[5]  = '{"exc_a",       32'h7F800000, 32'h12345678, 32'h00000000, 1'b1, 1};
        vecs[6]  = '{"exc_b",       32'h3F800000, 32'hFF800000, 32'h00000000, 1'b1, 1};
        vecs[7]  = '{"exp_ovf",     32'h7F000000, 32'hFF000000, 32'h00000000, 1'b1, 4};
        vecs[8]  = '{"swap_neg",    32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 4};
        vecs[9]  = '{"denormal",    32'h00800000, 32'h00400000, 32'h00600000, 1'b0, 4};
        vecs[10] = '{"shift3_norm", 32'h41000000, 32'h3F800000, 32'h40E00000, 1'b0, 7};
        vecs[11] = '{"align_24",    32'h3F800000, 32'h33800001, 32'h3F800000, 1'b0, 27};
        vecs[12] = '{"add_nocarry", 32'h40000000, 32'hBF800000, 32'h40400000, 1'b0, 4};
        vecs[13] = '{"neg_zero",    32'hBF800000, 32'hBF800000, 32'h00000000, 1'b0, 3};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = 32'd0;
        bus.b         = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    bus.result,         32'd0);
        check("rst_exception", 32'(bus.exception), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table of vectors, one operation at a time
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].lat);
            drain();
        end

        // Backpressure: result held, no acceptance while DONE waits
        bus.out_ready = 1'b0;
        drive("bp", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4);
        for (int n = 0; n < 50 && !bus.out_valid; n++) @(negedge clk);
        check("bp_valid_rise", 32'(bus.out_valid), 32'd1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp_hold_result", bus.result,         32'h40000000);
            check("bp_hold_valid",  32'(bus.out_valid), 32'd1);
            check("bp_in_ready",    32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_valid",    32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready),  32'd1);
        check("bp_scoreboard_empty", 32'(sb.size()),     32'd0);
        bus.out_ready = 1'b1;

        // Reset during alignment discards the operation
        drive("rst_flush", 32'h4E800000, 32'h3F800000, 32'h4E800000, 1'b0, 28);
        repeat (5) @(posedge clk);
        #2;
        check("align_busy",      32'(bus.busy),      32'd1);
        check("align_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_result",    bus.result,         32'd0);
        sb.delete();
        seen = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        drive("post_rst", 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 1'b0, 5);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
